// File: rtl/write_back_arbiter.sv
// Write-back arbiter: shares one register-file write port between ALU
// results and memory loads, with a 2-entry ALU holding FIFO.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   aluValid/Dest/Result  ALU write request; aluReady = accepted
//   memValid/Dest/Data    load write request; memReady = accepted
//   regWrite/regDest/writeData  registered register-file write
//   writeBackControl      source of current write (00 none/01 mem/10 ALU)
//   pendingCount          ALU entries waiting in the FIFO (0..2)
module write_back_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        aluValid,
    input  logic [4:0]  aluDest,
    input  logic [31:0] aluResult,
    output logic        aluReady,
    input  logic        memValid,
    input  logic [4:0]  memDest,
    input  logic [31:0] memData,
    output logic        memReady,
    output logic        regWrite,
    output logic [4:0]  regDest,
    output logic [31:0] writeData,
    output logic [1:0]  writeBackControl,
    output logic [1:0]  pendingCount
);

    localparam int SW =
        (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [36:0]   fifoMem0;
    logic [36:0]   fifoMem1;
    logic          rdPtr;
    logic          wrPtr;
    logic [1:0]    count;
    logic [SW-1:0] streak;

    logic          fifoEmpty;
    logic          starve;
    logic [36:0]   head;
    logic          grantHead;
    logic          grantMem;
    logic          grantAlu;
    logic          push;
    logic          pop;
    logic [4:0]    selDest;
    logic [31:0]   selData;
    logic [1:0]    selCtrl;

    assign fifoEmpty    = (count == 2'd0);
    assign head         = rdPtr ? fifoMem1 : fifoMem0;
    assign starve       = (streak == LIMIT) && !fifoEmpty;

    assign aluReady     = (count != 2'd2);
    assign memReady     = !starve;
    assign pendingCount = count;

    // Override beats memory; memory beats queued ALU; bypass last.
    assign grantHead = starve || (!memValid && !fifoEmpty);
    assign grantMem  = !starve && memValid;
    assign grantAlu  = !starve && !memValid && fifoEmpty && aluValid;

    // Accepted but not bypassed ALU requests are queued.
    assign push = aluValid && aluReady && !grantAlu;
    assign pop  = grantHead;

    always_comb begin
        selDest = 5'd0;
        selData = 32'd0;
        selCtrl = 2'b00;
        unique case (1'b1)
            grantHead: begin
                selDest = head[36:32];
                selData = head[31:0];
                selCtrl = 2'b10;
            end
            grantMem: begin
                selDest = memDest;
                selData = memData;
                selCtrl = 2'b01;
            end
            grantAlu: begin
                selDest = aluDest;
                selData = aluResult;
                selCtrl = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifoMem0         <= '0;
            fifoMem1         <= '0;
            rdPtr            <= 1'b0;
            wrPtr            <= 1'b0;
            count            <= 2'd0;
            streak           <= '0;
            regWrite         <= 1'b0;
            regDest          <= 5'd0;
            writeData        <= 32'd0;
            writeBackControl <= 2'b00;
        end else begin
            if (push) begin
                if (wrPtr) fifoMem1 <= {aluDest, aluResult};
                else       fifoMem0 <= {aluDest, aluResult};
                wrPtr <= ~wrPtr;
            end
            if (pop) rdPtr <= ~rdPtr;

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            if (fifoEmpty || grantHead)
                streak <= '0;
            else if (grantMem && streak != LIMIT)
                streak <= streak + SW'(1);

            // Writes to x0 still use the slot but never reach the file.
            regWrite         <= (selCtrl != 2'b00) && (selDest != 5'd0);
            regDest          <= selDest;
            writeData        <= selData;
            writeBackControl <= selCtrl;
        end
    end

endmodule

// File: tb/tb_write_back_arbiter.sv
// Self-checking bench for write_back_arbiter: reference model with an
// expected-write scoreboard plus directed scenario checks.
module tb_write_back_arbiter;

    logic        clk;
    logic        reset;
    logic        aluValid;
    logic [4:0]  aluDest;
    logic [31:0] aluResult;
    logic        aluReady;
    logic        memValid;
    logic [4:0]  memDest;
    logic [31:0] memData;
    logic        memReady;
    logic        regWrite;
    logic [4:0]  regDest;
    logic [31:0] writeData;
    logic [1:0]  writeBackControl;
    logic [1:0]  pendingCount;

    typedef struct packed {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
        logic [1:0]  ctrl;
    } wr_t;

    wr_t         expQ[$];
    logic [36:0] mq[$];
    int          streak;
    int          checks;
    int          passes;

    write_back_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk(clk),
        .reset(reset),
        .aluValid(aluValid),
        .aluDest(aluDest),
        .aluResult(aluResult),
        .aluReady(aluReady),
        .memValid(memValid),
        .memDest(memDest),
        .memData(memData),
        .memReady(memReady),
        .regWrite(regWrite),
        .regDest(regDest),
        .writeData(writeData),
        .writeBackControl(writeBackControl),
        .pendingCount(pendingCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        aluValid  = 1'b0;
        aluDest   = 5'd0;
        aluResult = 32'd0;
        memValid  = 1'b0;
        memDest   = 5'd0;
        memData   = 32'd0;
    endtask

    task automatic setAlu(input logic v, input logic [4:0] d,
                          input logic [31:0] r);
        aluValid  = v;
        aluDest   = d;
        aluResult = r;
    endtask

    task automatic setMem(input logic v, input logic [4:0] d,
                          input logic [31:0] r);
        memValid = v;
        memDest  = d;
        memData  = r;
    endtask

    // One clock: predict the grant from current inputs, check the
    // ready outputs, clock, then compare the registered write.
    task automatic tick();
        wr_t         e;
        wr_t         got;
        int          n;
        logic        st;
        logic        hd;
        logic        byp;
        logic [36:0] h;
        n   = mq.size();
        st  = (streak == 3) && (n > 0);
        hd  = 1'b0;
        byp = 1'b0;
        checks++;
        if (aluReady !== (n != 2))
            $display("FAIL aluReady: got %b expected %b",
                     aluReady, (n != 2));
        else passes++;
        checks++;
        if (memReady !== !st)
            $display("FAIL memReady: got %b expected %b",
                     memReady, !st);
        else passes++;
        e = '0;
        if (st || (!memValid && n > 0)) begin
            h      = mq.pop_front();
            hd     = 1'b1;
            e.ctrl = 2'b10;
            e.dest = h[36:32];
            e.data = h[31:0];
        end else if (memValid) begin
            e.ctrl = 2'b01;
            e.dest = memDest;
            e.data = memData;
        end else if (aluValid) begin
            byp    = 1'b1;
            e.ctrl = 2'b10;
            e.dest = aluDest;
            e.data = aluResult;
        end
        e.we = (e.ctrl != 2'b00) && (e.dest != 5'd0);
        if (aluValid && n != 2 && !byp)
            mq.push_back({aluDest, aluResult});
        if (n == 0 || hd) streak = 0;
        else if (!st && memValid && streak < 3) streak++;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        e        = expQ.pop_front();
        got.we   = regWrite;
        got.dest = regDest;
        got.data = writeData;
        got.ctrl = writeBackControl;
        checks++;
        if (got !== e)
            $display("FAIL write: got we=%b d=%0d v=%0h c=%b expected we=%b d=%0d v=%0h c=%b",
                     got.we, got.dest, got.data, got.ctrl,
                     e.we, e.dest, e.data, e.ctrl);
        else passes++;
        checks++;
        if (pendingCount !== 2'(mq.size()))
            $display("FAIL pendingCount: got %0d expected %0d",
                     pendingCount, mq.size());
        else passes++;
    endtask

    task automatic test_reset();
        checks++;
        if ({regWrite, regDest, writeData, writeBackControl} !== '0)
            $display("FAIL reset_outputs: got %b/%0d/%0h/%b expected 0",
                     regWrite, regDest, writeData, writeBackControl);
        else passes++;
        checks++;
        if ({pendingCount, aluReady, memReady} !== 4'b0011)
            $display("FAIL reset_ready: got %b expected 0011",
                     {pendingCount, aluReady, memReady});
        else passes++;
    endtask

    task automatic test_bypass();
        idle();
        setAlu(1'b1, 5'd5, 32'd200);
        tick();
        checks++;
        if ({regWrite, regDest, writeData, writeBackControl} !==
            {1'b1, 5'd5, 32'd200, 2'b10})
            $display("FAIL bypass: got %b/%0d/%0d/%b expected 1/5/200/10",
                     regWrite, regDest, writeData, writeBackControl);
        else passes++;
        idle();
        tick();
    endtask

    task automatic test_collision();
        idle();
        setAlu(1'b1, 5'd3, 32'd200);
        setMem(1'b1, 5'd4, 32'd100);
        tick();
        checks++;
        if ({writeBackControl, regDest, writeData, pendingCount} !==
            {2'b01, 5'd4, 32'd100, 2'd1})
            $display("FAIL collision_mem: got %b/%0d/%0d/%0d expected 01/4/100/1",
                     writeBackControl, regDest, writeData, pendingCount);
        else passes++;
        idle();
        tick();
        checks++;
        if ({writeBackControl, regDest, writeData, pendingCount} !==
            {2'b10, 5'd3, 32'd200, 2'd0})
            $display("FAIL collision_alu: got %b/%0d/%0d/%0d expected 10/3/200/0",
                     writeBackControl, regDest, writeData, pendingCount);
        else passes++;
        tick();
    endtask

    task automatic test_full();
        int aluWrites;
        idle();
        for (int i = 0; i < 3; i++) begin
            setMem(1'b1, 5'(10 + i), 32'(1000 + i));
            setAlu(1'b1, 5'(20 + i), 32'(2000 + i));
            if (i == 2) begin
                checks++;
                if (aluReady !== 1'b0)
                    $display("FAIL full_ready: got %b expected 0",
                             aluReady);
                else passes++;
            end
            tick();
        end
        checks++;
        if (pendingCount !== 2'd2)
            $display("FAIL full_count: got %0d expected 2",
                     pendingCount);
        else passes++;
        idle();
        aluWrites = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (writeBackControl == 2'b10) aluWrites++;
        end
        checks++;
        if (aluWrites != 2)
            $display("FAIL full_drain: got %0d alu writes expected 2",
                     aluWrites);
        else passes++;
    endtask

    task automatic test_starve();
        idle();
        setAlu(1'b1, 5'd7, 32'd777);
        setMem(1'b1, 5'd8, 32'd800);
        tick();
        setAlu(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            setMem(1'b1, 5'(9 + i), 32'(900 + i));
            tick();
        end
        setMem(1'b1, 5'd12, 32'd912);
        checks++;
        if (memReady !== 1'b0)
            $display("FAIL starve_ready: got %b expected 0", memReady);
        else passes++;
        tick();
        checks++;
        if ({writeBackControl, regDest, writeData} !==
            {2'b10, 5'd7, 32'd777})
            $display("FAIL starve_write: got %b/%0d/%0d expected 10/7/777",
                     writeBackControl, regDest, writeData);
        else passes++;
        checks++;
        if (memReady !== 1'b1)
            $display("FAIL starve_resume_ready: got %b expected 1",
                     memReady);
        else passes++;
        tick();
        checks++;
        if ({writeBackControl, regDest} !== {2'b01, 5'd12})
            $display("FAIL starve_resume: got %b/%0d expected 01/12",
                     writeBackControl, regDest);
        else passes++;
        idle();
        tick();
    endtask

    task automatic test_dest_zero();
        idle();
        setMem(1'b1, 5'd0, 32'hDEAD);
        tick();
        checks++;
        if ({regWrite, writeBackControl} !== 3'b001)
            $display("FAIL dest_zero: got %b/%b expected 0/01",
                     regWrite, writeBackControl);
        else passes++;
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            setAlu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   $urandom);
            setMem($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)),
                   $urandom);
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_reset_mid();
        idle();
        for (int i = 0; i < 2; i++) begin
            setMem(1'b1, 5'(1 + i), 32'(50 + i));
            setAlu(1'b1, 5'(15 + i), 32'(60 + i));
            tick();
        end
        checks++;
        if (pendingCount !== 2'd2)
            $display("FAIL mid_precount: got %0d expected 2",
                     pendingCount);
        else passes++;
        idle();
        #3;
        reset = 1'b1;
        #1;
        mq.delete();
        expQ.delete();
        streak = 0;
        checks++;
        if ({regWrite, regDest, writeData, writeBackControl} !== '0)
            $display("FAIL mid_outputs: got %b/%0d/%0h/%b expected 0",
                     regWrite, regDest, writeData, writeBackControl);
        else passes++;
        checks++;
        if ({pendingCount, aluReady, memReady} !== 4'b0011)
            $display("FAIL mid_ready: got %b expected 0011",
                     {pendingCount, aluReady, memReady});
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (regWrite !== 1'b0)
            $display("FAIL mid_held: got %b expected 0", regWrite);
        else passes++;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        streak = 0;
        reset  = 1'b1;
        idle();
        #12;
        test_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        test_bypass();
        test_collision();
        test_full();
        test_starve();
        test_dest_zero();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
